// File: rtl/pcie_msi_arbiter_if.sv
// MSI / legacy interrupt handshake between the arbiter and the PCIe hard IP.
// master = interrupt generator (drives requests), slave = hard IP (drives acks).
// Purely structural; no logic.
interface pcie_msi_arbiter_if;
  logic       app_msi_req;
  logic [4:0] app_msi_num;
  logic [2:0] app_msi_tc;
  logic       app_msi_ack;
  logic       app_int_sts;
  logic       app_int_ack;

  modport master (
    output app_msi_req,
    output app_msi_num,
    output app_msi_tc,
    output app_int_sts,
    input  app_msi_ack,
    input  app_int_ack
  );

  modport slave (
    input  app_msi_req,
    input  app_msi_num,
    input  app_msi_tc,
    input  app_int_sts,
    output app_msi_ack,
    output app_int_ack
  );
endinterface

// File: rtl/pcie_msi_arbiter.sv
// MSI generator: per-source edge/level capture into pending bits, RR or fixed-priority pick.
// Latency: irq edge at t -> pending at t+1 -> app_msi_req at t+2.
// Backpressure: request held until app_msi_ack; pending bits accumulate while stalled/masked/disabled.
module pcie_msi_arbiter #(
  parameter int                 NUM_IRQ     = 8,
  parameter logic [NUM_IRQ-1:0] LEVEL_MASK  = '0,
  parameter logic [2:0]         MSI_TC      = 3'b000,
  parameter int                 ROUND_ROBIN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               msi_enable,
  input  logic [2:0]         msi_multi_en,
  output logic [NUM_IRQ-1:0] irq_pending,
  pcie_msi_arbiter_if.master msi
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IRQ - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] irq_r;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] rot;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   base;
  logic               found;
  logic [2:0]         fold_n;
  logic [4:0]         vec_mask;
  logic [4:0]         pick_vec;
  logic               unused_int_ack;

  // Constant sideband outputs; the legacy INTx path is not used.
  assign msi.app_msi_tc  = MSI_TC;
  assign msi.app_int_sts = 1'b0;
  assign unused_int_ack  = msi.app_int_ack;
  assign irq_pending     = pending;

  // Level sources set every cycle they are high; edge sources only on a 0->1 transition.
  assign set_vec  = (irq & LEVEL_MASK) | (irq & ~irq_r & ~LEVEL_MASK);
  assign clr_vec  = (state == REQ && msi.app_msi_ack) ? (NUM_IRQ'(1) << sel) : '0;
  assign eligible = pending & ~irq_mask;

  // Rotate so the search start sits at bit 0, then take the lowest set bit and undo the rotation.
  always_comb begin
    base  = (ROUND_ROBIN != 0) ? rr_ptr : '0;
    rot   = NUM_IRQ'({eligible, eligible} >> base);
    found = 1'b0;
    pick  = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        if (int'(base) + k >= NUM_IRQ) begin
          pick = IDX_W'(int'(base) + k - NUM_IRQ);
        end else begin
          pick = IDX_W'(int'(base) + k);
        end
      end
    end
  end

  // Fold the source index onto the granted vector count (encodings 6,7 behave as 5).
  always_comb begin
    fold_n   = (msi_multi_en > 3'd5) ? 3'd5 : msi_multi_en;
    vec_mask = 5'((6'd1 << fold_n) - 6'd1);
    pick_vec = 5'(pick) & vec_mask;
  end

  // Edge history and pending bits; a new set in the ack cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_r   <= irq;
      pending <= '0;
    end else begin
      irq_r   <= irq;
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  // Request FSM: one MSI in flight, held stable until acked, then at least one idle cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      msi.app_msi_req <= 1'b0;
      msi.app_msi_num <= '0;
      sel             <= '0;
      rr_ptr          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (msi_enable && found) begin
            sel             <= pick;
            msi.app_msi_req <= 1'b1;
            msi.app_msi_num <= pick_vec;
            state           <= REQ;
          end
        end
        REQ: begin
          if (msi.app_msi_ack) begin
            msi.app_msi_req <= 1'b0;
            rr_ptr          <= (sel == LAST_IDX) ? '0 : sel + 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
